// File: rtl/if_id_stall_responder.sv
// Front-end PC / IF-ID register with hazard-unit stall controls, branch flush,
// zero-latency control bubble gate and a saturating stall-cycle counter.
module if_id_stall_responder #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CTRL_W    = 9,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pcw,
  input  logic              s1w,
  input  logic              mux,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic [31:0]       imem_instr,
  input  logic [CTRL_W-1:0] id_ctrl_in,
  output logic [31:0]       pc_out,
  output logic [31:0]       if_id_pc4,
  output logic [31:0]       if_id_instr,
  output logic              if_id_valid,
  output logic [CTRL_W-1:0] id_ctrl_out,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      if_id_pc4_q, if_id_pc4_d;
  logic [31:0]      if_id_instr_q, if_id_instr_d;
  logic             if_id_valid_q, if_id_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [31:0]      pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d          = pc_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    stall_cnt_d   = stall_cnt_q;
    // The branch is older than any stalled instruction, so the flush beats the hold.
    if (branch_taken) begin
      pc_d          = branch_target;
      if_id_pc4_d   = 32'd0;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end else begin
      if (pcw) begin
        pc_d = pc_plus4;
      end
      if (s1w) begin
        if_id_pc4_d   = pc_plus4;
        if_id_instr_d = imem_instr;
        if_id_valid_d = 1'b1;
      end
    end
    if (!pcw && !branch_taken && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      if_id_pc4_q   <= 32'd0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      pc_q          <= pc_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign pc_out      = pc_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;
  assign stall_cnt   = stall_cnt_q;
  assign id_ctrl_out = mux ? id_ctrl_in : '0;

endmodule
